// File: rtl/hb_rd_packer.sv
// hb_rd_packer: packs 2*DQ_WIDTH-bit read beats into OUT_WIDTH-bit words behind an FWFT FIFO with burst-last marking.
// Optional sticky overflow flag built when HB_RD_PACKER_OVF_EN is defined.
module hb_rd_packer #(
  parameter int DQ_WIDTH   = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic                          start,
  input  logic [15:0]                   burst_len,
  input  logic                          abort,
  input  logic [2*DQ_WIDTH-1:0]         in_data,
  input  logic                          in_vld,
  output logic                          busy,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf
);
  localparam int BW = 2 * DQ_WIDTH;
  localparam int R  = OUT_WIDTH / BW;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [15:0] word_cnt_q, word_cnt_d, len_q, len_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [OUT_WIDTH-1:0] asm_q, asm_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [OUT_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [OUT_WIDTH:0] head;
  logic start_ok, take, complete, is_last, pop, full, push;
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = start_ok ? RUN : IDLE;
    else state_d = (abort || (complete && is_last)) ? IDLE : RUN;
  end
  always_comb busy = (state_q == RUN);
  always_comb begin
    start_ok = !busy && start && (burst_len != 16'd0);
    take     = busy && in_vld && !abort;
    complete = take && (beat_cnt_q == CW'(R - 1));
    is_last  = (word_cnt_q == len_q - 16'd1);
    pop      = out_valid && out_ready;
    full     = (level_q == LW'(FIFO_DEPTH));
    push     = complete && (!full || pop);
    asm_d    = asm_q;
    for (int k = 0; k < R; k++)
      asm_d[k*BW +: BW] = (take && beat_cnt_q == CW'(k)) ? in_data : asm_q[k*BW +: BW];
    beat_cnt_d = (start_ok || abort || complete) ? '0 : take ? beat_cnt_q + CW'(1) : beat_cnt_q;
    word_cnt_d = start_ok ? 16'd0 : complete ? word_cnt_q + 16'd1 : word_cnt_q;
    len_d      = start_ok ? burst_len : len_q;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    level_d    = level_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      word_cnt_q <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      asm_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      mem_q      <= '{default: '0};
    end else begin
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      asm_q      <= asm_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      if (push) mem_q[wr_ptr_q] <= {is_last, asm_d};
    end
  end
  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_valid  = (level_q != '0);
    out_data   = out_valid ? head[OUT_WIDTH-1:0] : '0;
    out_last   = out_valid && head[OUT_WIDTH];
    fifo_level = level_q;
  end
`ifdef HB_RD_PACKER_OVF_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = (complete && full && !pop) || (ovf_q && !start_ok);
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_hb_rd_packer.sv
// tb_hb_rd_packer: directed checks of hb_rd_packer with DQ_WIDTH=8, OUT_WIDTH=32, FIFO_DEPTH=4.
module tb_hb_rd_packer;
  logic clk = 0, arstn = 1, start = 0, abort = 0, in_vld = 0, out_ready = 0;
  logic [15:0] burst_len = 0, in_data = 0;
  logic busy, out_last, out_valid, ovf;
  logic [31:0] out_data;
  logic [2:0] fifo_level;
  int checks = 0, errors = 0;
  logic [32:0] q[$];
`ifdef HB_RD_PACKER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  hb_rd_packer #(.DQ_WIDTH(8), .OUT_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .arstn(arstn), .start(start), .burst_len(burst_len), .abort(abort),
    .in_data(in_data), .in_vld(in_vld), .busy(busy), .out_data(out_data),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .ovf(ovf));

  always #5 clk = ~clk;
  always @(negedge clk) if (out_valid && out_ready) q.push_back({out_last, out_data});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] n);
    start = 1; burst_len = n; tick; start = 0;
  endtask

  task automatic beat(input logic [15:0] d);
    in_vld = 1; in_data = d; tick; in_vld = 0;
  endtask

  task automatic drain(input int n);
    int t = 0;
    out_ready = 1;
    while (out_valid && t < 50) begin tick; t++; end
    out_ready = 0;
    chk("drain_bound", 64'(t < 50), 64'd1);
    chk("drain_cnt", 64'(q.size()), 64'(n));
  endtask

  function automatic logic [15:0] bt(input int b, input int i);
    return {8'(b + 2*i + 1), 8'(b + 2*i)};
  endfunction

  initial begin
    #3 arstn = 0;
    #4;
    chk("rst_busy", busy, 0); chk("rst_valid", out_valid, 0); chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0); chk("rst_level", fifo_level, 0); chk("rst_ovf", ovf, 0);
    #10 arstn = 1;
    tick;
    // basic 3-word burst, consumer always ready
    q.delete(); out_ready = 1; go(3);
    for (int i = 0; i < 6; i++) begin
      beat(bt(0, i));
      if (i == 4) chk("t1_busy5", busy, 1);
    end
    chk("t1_busy6", busy, 0);
    drain(3);
    chk("t1_w0", q[0], {1'b0, 32'h03020100});
    chk("t1_w1", q[1], {1'b0, 32'h07060504});
    chk("t1_w2", q[2], {1'b1, 32'h0B0A0908});
    // overflow: 6 words into a 4-deep FIFO with no consumer
    q.delete(); go(6);
    for (int i = 0; i < 12; i++) beat(bt(0, i));
    chk("t2_level", fifo_level, 4); chk("t2_busy", busy, 0); chk("t2_ovf", ovf, OVF_EN);
    drain(4);
    chk("t2_w0", q[0], {1'b0, 32'h03020100});
    chk("t2_w3", q[3], {1'b0, 32'h0F0E0D0C});
    chk("t2_ovf_hold", ovf, OVF_EN);
    // abort after 3 beats, then a 1-word burst
    q.delete(); go(2);
    chk("t3_ovf_clr", ovf, 0);
    for (int i = 0; i < 3; i++) beat(bt(16'h10, i));
    abort = 1; tick; abort = 0;
    chk("t3_busy", busy, 0); chk("t3_level", fifo_level, 1);
    chk("t3_last", out_last, 0); chk("t3_data", out_data, 32'h13121110);
    go(1); beat(bt(16'h20, 0)); beat(bt(16'h20, 1));
    chk("t3_busy2", busy, 0); chk("t3_level2", fifo_level, 2);
    drain(2);
    chk("t3_w0", q[0], {1'b0, 32'h13121110});
    chk("t3_w1", q[1], {1'b1, 32'h23222120});
    // gapped input valid 1,0,0,1,1,0,1
    q.delete(); go(2);
    begin
      logic [6:0] pat;
      int n;
      pat = 7'b1011001;
      n = 0;
      for (int i = 0; i < 7; i++) begin
        if (pat[i]) begin beat(bt(16'h30, n)); n++; end
        else tick;
      end
    end
    chk("t4_busy", busy, 0); chk("t4_level", fifo_level, 2);
    drain(2);
    chk("t4_w0", q[0], {1'b0, 32'h33323130});
    chk("t4_w1", q[1], {1'b1, 32'h37363534});
    // push and pop together while full
    q.delete(); go(6);
    for (int i = 0; i < 9; i++) beat(bt(16'h40, i));
    chk("t5_full", fifo_level, 4);
    out_ready = 1; beat(bt(16'h40, 9)); out_ready = 0;
    chk("t5_level", fifo_level, 4); chk("t5_ovf", ovf, 0); chk("t5_busy", busy, 1);
    abort = 1; tick; abort = 0;
    drain(5);
    chk("t5_w0", q[0], {1'b0, 32'h43424140});
    chk("t5_w4", q[4], {1'b0, 32'h53525150});
    // async reset mid-burst with 2 words queued
    q.delete(); go(4);
    for (int i = 0; i < 5; i++) beat(bt(16'h60, i));
    chk("t6_level", fifo_level, 2);
    #2 arstn = 0;
    #1;
    chk("t6_busy", busy, 0); chk("t6_valid", out_valid, 0); chk("t6_data", out_data, 0);
    chk("t6_lvl0", fifo_level, 0); chk("t6_last", out_last, 0); chk("t6_ovf", ovf, 0);
    arstn = 1;
    tick;
    go(1); beat(bt(16'h70, 0)); beat(bt(16'h70, 1));
    chk("t6_word", out_data, 32'h73727170); chk("t6_wlast", out_last, 1);
    chk("t6_lvl1", fifo_level, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
